// File: rtl/router_pkg.sv
// Shared router constants: default widths, the reserved address code and the
// ordering of the FSM strobe bundle consumed by the datapath register stage.
package router_pkg;
  localparam int RTR_DATA_WIDTH = 8;
  localparam int RTR_ADDR_WIDTH = 2;

  // Address code 3 names no output port; headers carrying it are not latched.
  localparam logic [RTR_ADDR_WIDTH-1:0] INVALID_ADDR = 2'b11;

  // One-hot FSM state strobes, MSB first in this order.
  typedef struct packed {
    logic detect_add;
    logic lfd;
    logic ld;
    logic laf;
    logic full;
    logic rst_int;
  } fsm_strb_t;
endpackage

// File: rtl/router_parity_acc.sv
// XOR accumulator with synchronous clear (priority over enable) and async reset.
module router_parity_acc #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ din;
  end
endmodule

// File: rtl/router_data_reg.sv
// Router datapath register stage: header latch, FIFO byte staging, full-hold
// register and packet parity check. Build option: ROUTER_REG_LEN_CHECK_EN.
module router_data_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = RTR_DATA_WIDTH,
  parameter int ADDR_WIDTH = RTR_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);
  fsm_strb_t             strb;
  logic [DATA_WIDTH-1:0] hdr_reg, hold_reg, pkt_parity, parity_acc, acc_din;
  logic                  acc_en, new_pkt, hdr_ok, pd_q, mismatch;

  assign strb    = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg};
  assign new_pkt = strb.detect_add && pkt_valid;
  assign hdr_ok  = new_pkt && (data_in[ADDR_WIDTH-1:0] != {ADDR_WIDTH{1'b1}});

  // Every byte enters parity once: header on LFD, payload when sourced in LD
  // (even if the FIFO is full then); the full/laf replay adds nothing.
  assign acc_en  = !(strb.full || strb.laf) && (strb.lfd || (strb.ld && pkt_valid));
  assign acc_din = strb.lfd ? hdr_reg : data_in;

  router_parity_acc #(.W(DATA_WIDTH)) u_parity_acc (
    .clock  (clock),
    .resetn (resetn),
    .clr    (strb.detect_add),
    .en     (acc_en),
    .din    (acc_din),
    .acc    (parity_acc)
  );

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [DATA_WIDTH-ADDR_WIDTH-1:0] pay_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                    pay_cnt <= '0;
    else if (strb.detect_add)       pay_cnt <= '0;
    else if (strb.ld && pkt_valid)  pay_cnt <= pay_cnt + 1'b1;
  end

  assign mismatch = (parity_acc != pkt_parity) ||
                    (pay_cnt != hdr_reg[DATA_WIDTH-1:ADDR_WIDTH]);
`else
  assign mismatch = (parity_acc != pkt_parity);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_reg       <= '0;
      hold_reg      <= '0;
      pkt_parity    <= '0;
      dout          <= '0;
      low_pkt_valid <= 1'b0;
      parity_done   <= 1'b0;
      pd_q          <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (hdr_ok) hdr_reg <= data_in;

      if (strb.lfd)                   dout <= hdr_reg;
      else if (strb.ld && !fifo_full) dout <= data_in;
      else if (strb.laf)              dout <= hold_reg;

      if (strb.ld && fifo_full)  hold_reg   <= data_in;
      if (strb.ld && !pkt_valid) pkt_parity <= data_in;

      if (strb.ld && !pkt_valid) low_pkt_valid <= 1'b1;
      else if (strb.rst_int)     low_pkt_valid <= 1'b0;

      // Parity byte reaches the FIFO either directly or via the hold register.
      if ((strb.ld && !pkt_valid && !fifo_full) ||
          (strb.laf && low_pkt_valid && !parity_done))
        parity_done <= 1'b1;
      else if (new_pkt)
        parity_done <= 1'b0;

      pd_q <= parity_done;
      if (new_pkt)                      err <= 1'b0;
      else if (parity_done && !pd_q)    err <= mismatch;
    end
  end
endmodule
